// File: rtl/cs_window.sv
// cs_window: sliding window of the last N = 2^K+1 accepted samples with a
// running sum and an approximate-average result.
//   R = (S + N*Xappr) >> K, where A = floor(S/N) and Xappr is the largest
//   held sample not exceeding A (0 for an empty window).
// Y is loaded one edge after the accepting edge and is qualified by a
// one-cycle y_valid pulse. A pulse is produced only for accepts that leave
// the window full.
// Optional feature: define CS_AVG_OUT_EN to add the registered y_avg output
// (floor(S/N)), which is loaded together with Y.
module cs_window #(
    parameter int DW = 8,
    parameter int K  = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_valid,
    input  logic [DW-1:0] X,
    input  logic          flush,
    output logic [DW+1:0] Y,
    output logic          y_valid,
    output logic [K+1:0]  fill
`ifdef CS_AVG_OUT_EN
    ,
    output logic [DW-1:0] y_avg
`endif
);

    localparam int N  = (1 << K) + 1;
    localparam int FW = K + 2;
    localparam int SW = DW + K + 1;
    localparam int EW = SW + 2;
    localparam int RW = DW + 2;

    logic [DW-1:0] win_q [N];
    logic [DW-1:0] win_d [N];
    logic [SW-1:0] s_q, s_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          pend_q, pend_d;
    logic [RW-1:0] y_q, y_d;
    logic          y_valid_q, y_valid_d;

    logic [DW-1:0] avg;
    logic [DW-1:0] xappr;
    logic [EW-1:0] sum;
    logic [RW-1:0] res;

    // Window, running sum and fill update; flush has priority over a sample.
    always_comb begin
        win_d  = win_q;
        s_d    = s_q;
        fill_d = fill_q;
        pend_d = 1'b0;
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                win_d[i] = '0;
            end
            s_d    = '0;
            fill_d = '0;
        end else if (x_valid) begin
            if (fill_q < FW'(N)) begin
                for (int i = 0; i < N; i++) begin
                    if (FW'(i) == fill_q) begin
                        win_d[i] = X;
                    end
                end
                s_d    = s_q + SW'(X);
                fill_d = fill_q + FW'(1);
            end else begin
                for (int i = 0; i < N - 1; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[N-1] = X;
                s_d        = s_q - SW'(win_q[0]) + SW'(X);
            end
            pend_d = (fill_d == FW'(N));
        end
    end

    // Result from the registered window: average, nearest-below sample, R.
    always_comb begin
        avg   = DW'(s_q / SW'(N));
        xappr = '0;
        for (int i = 0; i < N; i++) begin
            if ((FW'(i) < fill_q) && (win_q[i] <= avg) && (win_q[i] > xappr)) begin
                xappr = win_q[i];
            end
        end
        sum = EW'(s_q) + EW'(xappr) * EW'(N);
        res = RW'(sum >> K);
    end

    // Output stage: Y and y_valid follow a pending accept by one edge.
    always_comb begin
        y_valid_d = pend_q;
        y_d       = pend_q ? res : y_q;
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
            s_q       <= '0;
            fill_q    <= '0;
            pend_q    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            win_q     <= win_d;
            s_q       <= s_d;
            fill_q    <= fill_d;
            pend_q    <= pend_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign Y       = y_q;
    assign y_valid = y_valid_q;
    assign fill    = fill_q;

`ifdef CS_AVG_OUT_EN
    logic [DW-1:0] y_avg_q, y_avg_d;

    // Average output loads alongside Y.
    always_comb begin
        y_avg_d = pend_q ? avg : y_avg_q;
    end

    // Average register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_avg_q <= '0;
        end else begin
            y_avg_q <= y_avg_d;
        end
    end

    assign y_avg = y_avg_q;
`endif

endmodule

// File: tb/tb_cs_window.sv
// Directed bench for cs_window: default instance (DW=8, K=3) and a small
// instance (DW=4, K=2). Optional y_avg checks follow CS_AVG_OUT_EN.
module tb_cs_window;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic       xv8 = 1'b0;
    logic [7:0] x8 = '0;
    logic       fl8 = 1'b0;
    logic [9:0] y8;
    logic       yv8;
    logic [4:0] fill8;

    logic       xv4 = 1'b0;
    logic [3:0] x4 = '0;
    logic       fl4 = 1'b0;
    logic [5:0] y4;
    logic       yv4;
    logic [3:0] fill4;

`ifdef CS_AVG_OUT_EN
    logic [7:0] avg8;
    logic [3:0] avg4;
`endif

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    cs_window #(.DW(8), .K(3)) u_dut8 (
        .clk(clk), .reset(reset), .x_valid(xv8), .X(x8), .flush(fl8),
        .Y(y8), .y_valid(yv8), .fill(fill8)
`ifdef CS_AVG_OUT_EN
        , .y_avg(avg8)
`endif
    );

    cs_window #(.DW(4), .K(2)) u_dut4 (
        .clk(clk), .reset(reset), .x_valid(xv4), .X(x4), .flush(fl4),
        .Y(y4), .y_valid(yv4), .fill(fill4)
`ifdef CS_AVG_OUT_EN
        , .y_avg(avg4)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive the 8-bit instance for one edge; outputs are stable afterwards.
    task automatic drv8(input logic v, input int x, input logic f);
        xv8 = v;
        x8  = 8'(x);
        fl8 = f;
        @(posedge clk);
        #1;
        xv8 = 1'b0;
        fl8 = 1'b0;
    endtask

    task automatic drv4(input logic v, input int x, input logic f);
        xv4 = v;
        x4  = 4'(x);
        fl4 = f;
        @(posedge clk);
        #1;
        xv4 = 1'b0;
        fl4 = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #1;
        reset = 1'b1;
        #1;
        chk("reset_y", int'(y8), 0);
        chk("reset_yv", int'(yv8), 0);
        chk("reset_fill", int'(fill8), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 0..8 back to back -> one pulse, Y=9
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            drv8(1'b1, i, 1'b0);
            pulses += int'(yv8);
        end
        chk("fill_full", int'(fill8), 9);
        drv8(1'b0, 0, 1'b0);
        chk("ramp_yv", int'(yv8), 1);
        chk("ramp_y", int'(y8), 9);
`ifdef CS_AVG_OUT_EN
        chk("ramp_avg", int'(avg8), 4);
`endif
        pulses += int'(yv8);
        drv8(1'b0, 0, 1'b0);
        pulses += int'(yv8);
        chk("ramp_pulses", pulses, 1);
        chk("hold_y", int'(y8), 9);

        // X=9 then X=10 with gaps
        drv8(1'b1, 9, 1'b0);
        chk("x9_latency", int'(yv8), 0);
        drv8(1'b0, 0, 1'b0);
        chk("x9_y", int'(y8), 11);
        drv8(1'b1, 10, 1'b0);
        drv8(1'b0, 0, 1'b0);
        chk("x10_y", int'(y8), 13);
        drv8(1'b0, 0, 1'b0);
        chk("x10_pulse_once", int'(yv8), 0);

        // Same ramp with 3-cycle gaps gives the same results
        pulse_reset();
        chk("mid_reset_y", int'(y8), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drv8(1'b1, i, 1'b0);
            pulses += int'(yv8);
            for (int g = 0; g < 3; g++) begin
                drv8(1'b0, 0, 1'b0);
                pulses += int'(yv8);
                if (g == 0 && i == 8) chk("gap_y9", int'(y8), 9);
            end
        end
        chk("gap_y11", int'(y8), 11);
        chk("gap_pulses", pulses, 2);

        // 255 x9 then eight zeros and 90
        drv8(1'b0, 0, 1'b1);
        chk("flush_fill", int'(fill8), 0);
        for (int i = 0; i < 9; i++) drv8(1'b1, 255, 1'b0);
        drv8(1'b0, 0, 1'b0);
        chk("max_y", int'(y8), 573);
`ifdef CS_AVG_OUT_EN
        chk("max_avg", int'(avg8), 255);
`endif
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            drv8(1'b1, (i == 8) ? 90 : 0, 1'b0);
            pulses += int'(yv8);
        end
        drv8(1'b0, 0, 1'b0);
        pulses += int'(yv8);
        chk("zero_xappr_y", int'(y8), 11);
        chk("b2b_pulses", pulses, 9);

        // Flush with a same-cycle sample after 5 samples
        drv8(1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) drv8(1'b1, i, 1'b0);
        drv8(1'b1, 7, 1'b1);
        chk("flush_drop_fill", int'(fill8), 0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            drv8(1'b1, i, 1'b0);
            pulses += int'(yv8);
        end
        chk("flush_refill_pulses", pulses, 0);
        drv8(1'b1, 9, 1'b0);
        chk("refill_y", int'(y8), 9);
        drv8(1'b1, 5, 1'b1);
        chk("flush_pending_yv", int'(yv8), 1);
        chk("flush_pending_y", int'(y8), 11);
        chk("flush_pending_fill", int'(fill8), 0);
        drv8(1'b0, 0, 1'b0);
        chk("flush_after_yv", int'(yv8), 0);
        chk("flush_keeps_y", int'(y8), 11);

        // Reset between edges after 7 samples
        for (int i = 0; i < 7; i++) drv8(1'b1, i, 1'b0);
        reset = 1'b1;
        #2;
        chk("async_fill", int'(fill8), 0);
        chk("async_y", int'(y8), 0);
        chk("async_yv", int'(yv8), 0);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) drv8(1'b1, i, 1'b0);
        drv8(1'b1, 9, 1'b0);
        chk("post_reset_y", int'(y8), 9);
        pulse_reset();
        drv8(1'b0, 0, 1'b0);
        chk("reset_drops_pending", int'(yv8), 0);
        chk("reset_drops_y", int'(y8), 0);

        // Small instance, N=5
        for (int i = 0; i < 5; i++) drv4(1'b1, 15, 1'b0);
        drv4(1'b0, 0, 1'b0);
        chk("k2_max_yv", int'(yv4), 1);
        chk("k2_max_y", int'(y4), 37);
`ifdef CS_AVG_OUT_EN
        chk("k2_max_avg", int'(avg4), 15);
`endif
        for (int i = 1; i <= 5; i++) drv4(1'b1, i, 1'b0);
        drv4(1'b0, 0, 1'b0);
        chk("k2_ramp_y", int'(y4), 7);
        chk("k2_fill", int'(fill4), 5);
`ifdef CS_AVG_OUT_EN
        chk("k2_ramp_avg", int'(avg4), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
